// File: rtl/soc_pio_pkg.sv
// soc_pio_pkg: register offsets, edge-type encodings and clog2 shared by the PIO blocks
package soc_pio_pkg;
  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((longint'(1) << r) < longint'(n)) r++;
    return r;
  endfunction
endpackage

// File: rtl/soc_debounce_bit.sv
// soc_debounce_bit: 2-flop synchronizer plus stability counter for one input pin
//  clk, reset_n (async, active-low), in_pin (asynchronous pin), stable (debounced level)
module soc_debounce_bit
  import soc_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_pin,
  output logic stable
);
  localparam int CW = DEBOUNCE_CYCLES > 0 ? clog2(DEBOUNCE_CYCLES + 1) : 1;
  logic s1, s2;
  logic [CW-1:0] cnt;
  // cnt counts consecutive cycles where s2 disagrees with stable; it is cleared
  // before it can reach DEBOUNCE_CYCLES, so it never wraps
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1     <= RESET_VALUE;
      s2     <= RESET_VALUE;
      stable <= RESET_VALUE;
      cnt    <= '0;
    end else begin
      s1 <= in_pin;
      s2 <= s1;
      if (DEBOUNCE_CYCLES == 0) stable <= s2;
      else if (s2 == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/soc_button_in.sv
// soc_button_in: Avalon-MM input PIO with debounce, edge capture and maskable level irq
//  clk, reset_n (async, active-low); address/chipselect/write_n/writedata: slave bus
//  in_port: external pins; readdata: registered read data; irq: (edge_capture & irq_mask) != 0
module soc_button_in
  import soc_pio_pkg::*;
#(
  parameter int               WIDTH           = 3,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] stable, stable_d, edge_capture, irq_mask;
  logic [WIDTH-1:0] ev, clr, ec_next, mask_next;
  logic [31:0] rd_mux;
  logic wr;
  logic unused_wd;
  assign unused_wd = ^writedata;
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    soc_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE(RESET_VALUE[i])
    ) u_db (
      .clk(clk),
      .reset_n(reset_n),
      .in_pin(in_port[i]),
      .stable(stable[i])
    );
  end
  // a capture event and a write-1-to-clear on the same bit leaves the bit set
  always_comb begin
    wr = chipselect && !write_n;
    ev = EDGE_TYPE == EDGE_RISE ? stable & ~stable_d :
         EDGE_TYPE == EDGE_FALL ? ~stable & stable_d : stable ^ stable_d;
    clr = wr && address == PIO_EDGECAP ? writedata[WIDTH-1:0] : '0;
    ec_next = (edge_capture & ~clr) | ev;
    mask_next = wr && address == PIO_IRQMASK ? writedata[WIDTH-1:0] : irq_mask;
    rd_mux = address == PIO_DATA    ? 32'(stable) :
             address == PIO_IRQMASK ? 32'(irq_mask) :
             address == PIO_EDGECAP ? 32'(edge_capture) : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stable_d     <= RESET_VALUE;
      edge_capture <= '0;
      irq_mask     <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      stable_d     <= stable;
      edge_capture <= ec_next;
      irq_mask     <= mask_next;
      readdata     <= chipselect ? rd_mux : 32'd0;
      irq          <= |(ec_next & mask_next);
    end
endmodule

// File: tb/tb_soc_button_in.sv
// tb_soc_button_in: rise/fall/any-edge instances checked against a behavioural model
module tb_soc_button_in;
  localparam int DC = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [1:0] address = '0;
  logic chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [2:0] in_port = '0;
  logic [31:0] rd[3];
  logic irq[3];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;

  soc_button_in #(.WIDTH(3), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0), .RESET_VALUE(3'b000)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq[0]));
  soc_button_in #(.WIDTH(3), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1), .RESET_VALUE(3'b000)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq[1]));
  soc_button_in #(.WIDTH(3), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2), .RESET_VALUE(3'b000)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq[2]));

  // model: pins seen at each edge since reset; a bit's accepted level flips once the
  // last DC synchronized samples (pins delayed two edges) all disagree with it
  logic [2:0] hist[$], samp[$];
  logic [2:0] m_stable, m_stabled, m_mask;
  logic [2:0] m_ec[3];
  logic m_irq[3];
  logic [31:0] m_rd[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    samp.delete();
    m_stable = '0;
    m_stabled = '0;
    m_mask = '0;
    for (int j = 0; j < 3; j++) begin
      m_ec[j] = '0;
      m_irq[j] = 1'b0;
      m_rd[j] = '0;
    end
  endtask

  task automatic model_edge(input logic [2:0] p, input logic c, input logic w,
                            input logic [1:0] a, input logic [31:0] d);
    logic [2:0] ns, ev, clr, nm;
    logic flip, wr;
    for (int j = 0; j < 3; j++)
      m_rd[j] = !c ? 32'd0 : a == 2'd0 ? {29'd0, m_stable} : a == 2'd2 ? {29'd0, m_mask} :
                a == 2'd3 ? {29'd0, m_ec[j]} : 32'd0;
    hist.push_back(p);
    samp.push_back(hist.size() >= 3 ? hist[hist.size() - 3] : 3'b000);
    if (hist.size() > 16) hist.pop_front();
    if (samp.size() > 16) samp.pop_front();
    ns = m_stable;
    if (samp.size() >= DC)
      for (int i = 0; i < 3; i++) begin
        flip = 1'b1;
        for (int k = 1; k <= DC; k++)
          if (samp[samp.size() - k][i] == m_stable[i]) flip = 1'b0;
        if (flip) ns[i] = ~m_stable[i];
      end
    wr = c && !w;
    clr = (wr && a == 2'd3) ? d[2:0] : 3'b000;
    nm = (wr && a == 2'd2) ? d[2:0] : m_mask;
    for (int j = 0; j < 3; j++) begin
      ev = j == 0 ? (m_stable & ~m_stabled) : j == 1 ? (~m_stable & m_stabled) : (m_stable ^ m_stabled);
      m_ec[j] = (m_ec[j] & ~clr) | ev;
      m_irq[j] = |(m_ec[j] & nm);
    end
    m_stabled = m_stable;
    m_stable = ns;
    m_mask = nm;
  endtask

  task automatic step(input logic [2:0] p, input logic c, input logic w,
                      input logic [1:0] a, input logic [31:0] d);
    in_port = p;
    chipselect = c;
    write_n = w;
    address = a;
    writedata = d;
    @(posedge clk);
    #1;
    model_edge(p, c, w, a, d);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("readdata[%0d]", j), rd[j], m_rd[j]);
      chk($sformatf("irq[%0d]", j), {31'd0, irq[j]}, {31'd0, m_irq[j]});
    end
  endtask

  task automatic rd_step(input logic [2:0] p, input logic [1:0] a);
    step(p, 1'b1, 1'b1, a, 32'd0);
  endtask

  task automatic wr_step(input logic [2:0] p, input logic [1:0] a, input logic [31:0] d);
    step(p, 1'b1, 1'b0, a, d);
  endtask

  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("async_rd[%0d]", j), rd[j], 32'd0);
      chk($sformatf("async_irq[%0d]", j), {31'd0, irq[j]}, 32'd0);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #12;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("reset_rd[%0d]", j), rd[j], 32'd0);
      chk($sformatf("reset_irq[%0d]", j), {31'd0, irq[j]}, 32'd0);
    end
    #5 reset_n = 1'b1;
    // data latency: 2 sync + 4 debounce, then 1 read cycle
    for (int k = 1; k <= 8; k++) begin
      rd_step(3'b101, 2'd0);
      if (k == 6) chk("t1_early", rd[0], 32'd0);
      if (k == 7) chk("t1_data", rd[0], 32'd5);
    end
    repeat (8) rd_step(3'b000, 2'd0);
    wr_step(3'b000, 2'd3, 32'h7);
    // bouncing bit0 never settles
    for (int k = 0; k < 20; k++) rd_step(3'((k / 2) % 2), 2'd3);
    repeat (8) rd_step(3'b000, 2'd3);
    chk("t2_ec_rise", rd[0], 32'd0);
    chk("t2_ec_any", rd[2], 32'd0);
    chk("t2_irq", {31'd0, irq[2]}, 32'd0);
    // masked capture raises irq, write-1-to-clear drops it
    wr_step(3'b000, 2'd2, 32'h2);
    for (int k = 1; k <= 8; k++) begin
      rd_step(3'b010, 2'd3);
      if (k == 6) chk("t3_irq_early", {31'd0, irq[0]}, 32'd0);
      if (k == 7) chk("t3_irq_set", {31'd0, irq[0]}, 32'd1);
    end
    chk("t3_ec", rd[0], 32'd2);
    wr_step(3'b010, 2'd3, 32'h2);
    chk("t3_irq_clr", {31'd0, irq[0]}, 32'd0);
    rd_step(3'b010, 2'd3);
    chk("t3_ec_clr", rd[0], 32'd0);
    // clear lands on the same edge as bit2's capture: set wins
    for (int k = 1; k <= 6; k++) rd_step(3'b110, 2'd3);
    wr_step(3'b110, 2'd3, 32'h4);
    rd_step(3'b110, 2'd3);
    chk("t4_set_wins", rd[0], 32'd4);
    // edge type variants on bit0
    repeat (8) rd_step(3'b000, 2'd3);
    wr_step(3'b000, 2'd3, 32'h7);
    wr_step(3'b000, 2'd2, 32'h1);
    repeat (8) rd_step(3'b001, 2'd3);
    chk("t5_rise_r", rd[0], 32'd1);
    chk("t5_rise_f", rd[1], 32'd0);
    chk("t5_rise_a", rd[2], 32'd1);
    chk("t5_irq_f", {31'd0, irq[1]}, 32'd0);
    wr_step(3'b001, 2'd3, 32'h1);
    repeat (8) rd_step(3'b000, 2'd3);
    chk("t5_fall_r", rd[0], 32'd0);
    chk("t5_fall_f", rd[1], 32'd1);
    chk("t5_fall_a", rd[2], 32'd1);
    repeat (4) rd_step(3'b000, 2'd0);
    chk("t5_irq_hold", {31'd0, irq[2]}, 32'd1);
    // reset mid-debounce with irq asserted
    repeat (3) rd_step(3'b111, 2'd0);
    pulse_reset();
    for (int k = 1; k <= 7; k++) begin
      rd_step(3'b111, 2'd0);
      if (k == 6) chk("t6_restart", rd[0], 32'd0);
      if (k == 7) chk("t6_data", rd[0], 32'd7);
    end
    wr_step(3'b111, 2'd0, 32'hFFFF_FFFF);
    wr_step(3'b111, 2'd1, 32'hFFFF_FFFF);
    rd_step(3'b111, 2'd1);
    chk("t6_rsvd", rd[0], 32'd0);
    rd_step(3'b111, 2'd2);
    chk("t6_mask", rd[0], 32'd0);
    rd_step(3'b111, 2'd0);
    chk("t6_data_kept", rd[0], 32'd7);
    // random pins held for random spans, random bus traffic
    repeat (80) begin
      logic [2:0] p;
      int hold;
      p = 3'($urandom);
      hold = $urandom_range(1, 7);
      repeat (hold)
        step(p, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 2'($urandom), $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
